bit_serial_sample_emitter: RTL and testbench
============================================

BIT_SERIAL_SAMPLE_EMITTER -- requirements
Module: bit_serial_sample_emitter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_BANK, 8, samples dimensions emitted per bit-plane (power of two).
- MAX_DEPTH_BITS, 9, width of the dimension index.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- numBits_minus_1, in, 6, bit-planes per chunk minus 1.
- data_dim_minus_1, in, MAX_DEPTH_BITS+1, sample dimensions minus 1.
- in_valid, in, 1, input chunk valid.
- in_ready, out, 1, input chunk accepted when high with in_valid.
- in_data, in, NUM_BANK x 32, NUM_BANK fixed-point dimensions; lane i goes to a[i].
- a_valid, out, 1, bit-plane valid.
- a, out, NUM_BANK, bit-plane; a[i] is the current bit of lane i.
- a_first, out, 1, first plane of a sample.
- a_last, out, 1, last plane of a sample.
- busy, out, 1, chunk held or being emitted.

Function
REQ-003 Each accepted chunk SHALL be emitted as P = min(numBits_minus_1,31)+1 consecutive planes, MSB first: plane k carries bit (31-k) of every lane.
REQ-004 Emission SHALL have no backpressure; a_valid SHALL be high on every plane cycle, with no gaps while chunks are available.
REQ-005 The FSM SHALL have two states, IDLE and EMIT.
- IDLE->EMIT on in_valid&&in_ready.
- EMIT->IDLE after the last plane, when no next chunk is held or offered.
REQ-006 First-plane latency SHALL be 1 cycle: a chunk accepted at edge N is on a at edge N+1.
REQ-007 A one-entry holding buffer SHALL exist; in_ready = ~hold_valid.
- While EMIT with buffer empty, an accepted chunk goes to the buffer.
REQ-008 On the last-plane cycle, the next chunk SHALL load from the buffer if full, else directly from the input if in_valid, so back-to-back chunks emit with zero bubble.
REQ-009 numBits_minus_1 and data_dim_minus_1 SHALL be latched when the first chunk of a sample is loaded into the shift register.
- They SHALL be held constant until that sample's a_last.
REQ-010 Plane counter bit_idx (5b) SHALL run 0..P-1 and wrap to 0.
- Dimension counter dim_idx SHALL start at 0 and increment by NUM_BANK at each wrap.
REQ-011 A chunk SHALL be the last of its sample when dim_idx+NUM_BANK > latched data_dim_minus_1; dim_idx then returns to 0.
- data_dim SHALL be a multiple of NUM_BANK; other values are illegal.
REQ-012 a_first SHALL be high when bit_idx==0 && dim_idx==0.
REQ-013 a_last SHALL be high when bit_idx==P-1 on the last chunk.
- For P=1 with one chunk per sample, a_first and a_last SHALL be high together.
REQ-014 in_data SHALL be consumed raw; no sign extension or rounding.
REQ-015 busy SHALL equal (state==EMIT)||hold_valid.

Reset
REQ-016 On rst_n low (asynchronous), the block SHALL clear state, all counters, hold_valid, and the latched parameters.
- Outputs SHALL be a_valid=0, a=0, a_first=0, a_last=0, busy=0, in_ready=0.
REQ-017 in_ready SHALL go high on the first clock edge after rst_n deasserts.
- A partially emitted sample SHALL be discarded with no further planes.

Verification
REQ-018 NUM_BANK=8, numBits_minus_1=3, data_dim_minus_1=7, lane0=0xA0000000, other lanes 0 -> a[0] = 1,0,1,0 on 4 consecutive cycles; a_first on plane 0, a_last on plane 3.
REQ-019 data_dim_minus_1=15, numBits_minus_1=31, two chunks offered back-to-back -> 64 contiguous a_valid cycles; a_first only on cycle 0; a_last only on cycle 63; second in_ready low until the buffer drains.
REQ-020 numBits_minus_1=0, data_dim_minus_1=7, 3 chunks on consecutive cycles -> 3 contiguous planes, each with a_first=a_last=1, carrying bit 31 of each chunk.
REQ-021 numBits_minus_1 changed from 7 to 1 mid-sample -> the current sample keeps P=8; the next sample uses P=2.
REQ-022 rst_n pulsed low during plane 5 of 8 -> a_valid=0 immediately; no further planes; in_ready=1 one edge after release; a fresh chunk is then emitted from plane 0 with a_first=1.
REQ-023 in_valid held continuously with P=4 -> in_ready duty is one chunk per 4 cycles; the 0/1 bit pattern on every lane matches the software transpose of the input.

Source files
------------

// File: rtl/bit_serial_sample_emitter.sv
// Bit-serial emitter: transposes NUM_BANK 32-bit lanes into MSB-first bit-planes,
// with a one-entry holding buffer so back-to-back chunks stream without bubbles.
module bit_serial_sample_emitter #(
    parameter int unsigned NUM_BANK       = 8,
    parameter int unsigned MAX_DEPTH_BITS = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  numBits_minus_1,
    input  logic [MAX_DEPTH_BITS:0]     data_dim_minus_1,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BANK*32-1:0]      in_data,
    output logic                        a_valid,
    output logic [NUM_BANK-1:0]         a,
    output logic                        a_first,
    output logic                        a_last,
    output logic                        busy
);

    localparam int unsigned DW     = MAX_DEPTH_BITS + 1;
    localparam int unsigned DATA_W = NUM_BANK * 32;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              started_q;
    logic [4:0]        bit_idx_q, bit_idx_d;
    logic [DW-1:0]     dim_idx_q, dim_idx_d;
    logic [4:0]        plast_q, plast_d;
    logic [DW-1:0]     ddim_q, ddim_d;

    logic [DW:0]       dim_sum;
    logic [DW-1:0]     next_dim;
    logic              chunk_last;
    logic              plane_last;
    logic              accept;
    logic              load;
    logic              load_from_hold;
    logic [4:0]        nb_clamped;

    assign dim_sum    = {1'b0, dim_idx_q} + (DW + 1)'(NUM_BANK);
    assign chunk_last = dim_sum > {1'b0, ddim_q};
    assign plane_last = (bit_idx_q == plast_q);
    assign nb_clamped = (numBits_minus_1 > 6'd31) ? 5'd31 : numBits_minus_1[4:0];

    assign in_ready = started_q & ~hold_valid_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        hold_d         = hold_q;
        hold_valid_d   = hold_valid_q;
        bit_idx_d      = bit_idx_q;
        dim_idx_d      = dim_idx_q;
        plast_d        = plast_q;
        ddim_d         = ddim_q;
        next_dim       = dim_idx_q;
        load           = 1'b0;
        load_from_hold = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    state_d   = EMIT;
                    bit_idx_d = '0;
                end
            end
            default: begin
                for (int unsigned i = 0; i < NUM_BANK; i++) begin
                    data_d[i*32 +: 32] = {data_q[i*32 +: 31], 1'b0};
                end
                if (!plane_last) begin
                    bit_idx_d = bit_idx_q + 5'd1;
                    if (accept) begin
                        hold_d       = in_data;
                        hold_valid_d = 1'b1;
                    end
                end else begin
                    bit_idx_d = '0;
                    next_dim  = chunk_last ? '0 : dim_sum[DW-1:0];
                    dim_idx_d = next_dim;
                    // Buffered chunk has priority; otherwise take the input directly for zero bubble.
                    if (hold_valid_q) begin
                        load           = 1'b1;
                        load_from_hold = 1'b1;
                        hold_valid_d   = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        if (load) begin
            data_d = load_from_hold ? hold_q : in_data;
            if (next_dim == '0) begin
                plast_d = nb_clamped;
                ddim_d  = data_dim_minus_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            started_q    <= 1'b0;
            bit_idx_q    <= '0;
            dim_idx_q    <= '0;
            plast_q      <= '0;
            ddim_q       <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            started_q    <= 1'b1;
            bit_idx_q    <= bit_idx_d;
            dim_idx_q    <= dim_idx_d;
            plast_q      <= plast_d;
            ddim_q       <= ddim_d;
        end
    end

    assign a_valid = (state_q == EMIT);

    always_comb begin
        a = '0;
        if (a_valid) begin
            for (int unsigned i = 0; i < NUM_BANK; i++) begin
                a[i] = data_q[i*32 + 31];
            end
        end
    end

    assign a_first = a_valid && (bit_idx_q == '0) && (dim_idx_q == '0);
    assign a_last  = a_valid && plane_last && chunk_last;
    assign busy    = a_valid | hold_valid_q;

endmodule

// File: tb/tb_bit_serial_sample_emitter.sv
// Directed bench for bit_serial_sample_emitter: single-chunk vector table plus
// streaming sequences for buffering, parameter latching and reset corners.
module tb_bit_serial_sample_emitter;

    localparam int NB = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   nbm1;
    logic [9:0]   ddm1;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         a_valid;
    logic [7:0]   a;
    logic         a_first;
    logic         a_last;
    logic         busy;

    bit_serial_sample_emitter #(.NUM_BANK(8), .MAX_DEPTH_BITS(9)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .numBits_minus_1  (nbm1),
        .data_dim_minus_1 (ddm1),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .a_valid          (a_valid),
        .a                (a),
        .a_first          (a_first),
        .a_last           (a_last),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [255:0] chunks [8];
    int           p_of   [8];
    int           acc_at [8];
    logic         rdy_hist [64];

    typedef struct {
        logic [5:0]  nb;
        logic [31:0] l0;
        logic [31:0] l7;
        int          p;
        logic [31:0] e0;
        logic [31:0] e7;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_chunks(input int seed);
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < NB; i++) begin
                chunks[j][i*32 +: 32] = (32'h9E3779B9 * (seed * 64 + j * 8 + i + 1)) ^ 32'h5A3C_96E1;
            end
        end
    endtask

    // Streams n chunks with in_valid held; expected planes are the lane transpose.
    task automatic stream(input int n, input logic [5:0] nb0, input logic [5:0] nb1,
                          input logic [9:0] dd, input int cps, input string tag);
        int total, j, k, fi;
        logic acc;
        logic [7:0] ea;
        total = 0;
        for (int q = 0; q < n; q++) total += p_of[q];
        for (int q = 0; q < 8; q++) acc_at[q] = -99;
        @(negedge clk);
        chk({tag, " start_ready"}, 64'(in_ready), 64'd1);
        nbm1 = nb0; ddm1 = dd; in_valid = 1'b1; in_data = chunks[0];
        fi = 0; acc = in_ready; acc_at[0] = -1; j = 0; k = 0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 1) nbm1 = nb1;
            for (int i = 0; i < NB; i++) ea[i] = chunks[j][i*32 + 31 - k];
            chk($sformatf("%s valid c%0d", tag, c), 64'(a_valid), 64'd1);
            chk($sformatf("%s a c%0d", tag, c), 64'(a), 64'(ea));
            chk($sformatf("%s first c%0d", tag, c), 64'(a_first), 64'((j % cps == 0) && (k == 0)));
            chk($sformatf("%s last c%0d", tag, c), 64'(a_last),
                64'((j % cps == cps - 1) && (k == p_of[j] - 1)));
            if (c < 64) rdy_hist[c] = in_ready;
            if (acc) fi++;
            in_valid = (fi < n);
            if (fi < n) in_data = chunks[fi];
            acc = in_valid && in_ready;
            if (acc) acc_at[fi] = c;
            k++;
            if (k == p_of[j]) begin
                k = 0;
                j++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, " all_accepted"}, 64'(fi), 64'(n));
        chk({tag, " end_valid"}, 64'(a_valid), 64'd0);
        chk({tag, " end_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        tbl[0] = '{nb: 6'd3,  l0: 32'hA0000000, l7: 32'h00000000, p: 4,  e0: 32'hA0000000, e7: 32'h00000000};
        tbl[1] = '{nb: 6'd0,  l0: 32'h80000000, l7: 32'h7FFFFFFF, p: 1,  e0: 32'h80000000, e7: 32'h00000000};
        tbl[2] = '{nb: 6'd40, l0: 32'h12345678, l7: 32'hDEADBEEF, p: 32, e0: 32'h12345678, e7: 32'hDEADBEEF};
        tbl[3] = '{nb: 6'd7,  l0: 32'h0F0000FF, l7: 32'hF00000AA, p: 8,  e0: 32'h0F000000, e7: 32'hF0000000};
        tbl[4] = '{nb: 6'd3,  l0: 32'hA5A5A5A5, l7: 32'h5A5A5A5A, p: 4,  e0: 32'hA0000000, e7: 32'h50000000};

        rst_n = 1'b0; in_valid = 1'b0; nbm1 = '0; ddm1 = 10'd7; in_data = '0;
        @(negedge clk); @(negedge clk);
        chk("rst a_valid", 64'(a_valid), 64'd0);
        chk("rst a", 64'(a), 64'd0);
        chk("rst a_first", 64'(a_first), 64'd0);
        chk("rst a_last", 64'(a_last), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(in_ready), 64'd1);

        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d ready", t), 64'(in_ready), 64'd1);
            nbm1 = tbl[t].nb; ddm1 = 10'd7;
            in_data = '0;
            in_data[31:0] = tbl[t].l0;
            in_data[255:224] = tbl[t].l7;
            in_valid = 1'b1;
            for (int k = 0; k < tbl[t].p; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                chk($sformatf("tbl%0d valid k%0d", t, k), 64'(a_valid), 64'd1);
                chk($sformatf("tbl%0d a0 k%0d", t, k), 64'(a[0]), 64'(tbl[t].e0[31 - k]));
                chk($sformatf("tbl%0d a7 k%0d", t, k), 64'(a[7]), 64'(tbl[t].e7[31 - k]));
                chk($sformatf("tbl%0d mid k%0d", t, k), 64'(a[6:1]), 64'd0);
                chk($sformatf("tbl%0d first k%0d", t, k), 64'(a_first), 64'(k == 0));
                chk($sformatf("tbl%0d last k%0d", t, k), 64'(a_last), 64'(k == tbl[t].p - 1));
            end
            @(negedge clk);
            chk($sformatf("tbl%0d idle_valid", t), 64'(a_valid), 64'd0);
            chk($sformatf("tbl%0d idle_busy", t), 64'(busy), 64'd0);
        end

        // Two chunks of one 16-dim sample, 32 planes each.
        fill_chunks(1);
        p_of[0] = 32; p_of[1] = 32;
        stream(2, 6'd31, 6'd31, 10'd15, 2, "b2b");
        chk("b2b second_accept", 64'(acc_at[1]), 64'd0);
        lows = 0;
        for (int c = 1; c < 32; c++) if (rdy_hist[c] == 1'b0) lows++;
        chk("b2b ready_low_cycles", 64'(lows), 64'd31);
        chk("b2b ready_after_drain", 64'(rdy_hist[32]), 64'd1);

        // Single-plane samples on consecutive cycles.
        fill_chunks(2);
        p_of[0] = 1; p_of[1] = 1; p_of[2] = 1;
        stream(3, 6'd0, 6'd0, 10'd7, 1, "p1");
        chk("p1 accept1", 64'(acc_at[1]), 64'd0);
        chk("p1 accept2", 64'(acc_at[2]), 64'd1);

        // numBits changes mid-sample: current sample keeps P=8, next uses P=2.
        fill_chunks(3);
        p_of[0] = 8; p_of[1] = 8; p_of[2] = 2; p_of[3] = 2;
        stream(4, 6'd7, 6'd1, 10'd15, 2, "latch");

        // Continuous in_valid at P=4: one acceptance every 4 cycles.
        fill_chunks(4);
        for (int q = 0; q < 6; q++) p_of[q] = 4;
        stream(6, 6'd3, 6'd3, 10'd7, 1, "duty");
        chk("duty accept1", 64'(acc_at[1]), 64'd0);
        for (int q = 2; q < 6; q++) chk($sformatf("duty gap%0d", q), 64'(acc_at[q] - acc_at[q-1]), 64'd4);

        // Reset during plane 5 of 8.
        fill_chunks(5);
        @(negedge clk);
        nbm1 = 6'd7; ddm1 = 10'd7; in_data = chunks[0]; in_valid = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("rstmid plane5_valid", 64'(a_valid), 64'd1);
        chk("rstmid plane5_a", 64'(a[0]), 64'(chunks[0][31 - 5]));
        rst_n = 1'b0;
        #1;
        chk("rstmid valid", 64'(a_valid), 64'd0);
        chk("rstmid a", 64'(a), 64'd0);
        chk("rstmid busy", 64'(busy), 64'd0);
        chk("rstmid ready", 64'(in_ready), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rstmid ready_pre", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rstmid ready_post", 64'(in_ready), 64'd1);
        chk("rstmid no_planes", 64'(a_valid), 64'd0);
        fill_chunks(6);
        p_of[0] = 4;
        stream(1, 6'd3, 6'd3, 10'd7, 1, "fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
